// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 block sequencer slice.
//   block_size(mode) : message block size in bits for a digest variant
//   WPB              : words written per block
//   seq_state_e      : sequencer FSM states
//   PAD_*            : bit positions within the padding-unit control bus
package sha2_pkg;

    localparam int unsigned WPB = 16;

    // Padding-unit control bus bit positions.
    localparam int unsigned PAD_CLR     = 0;
    localparam int unsigned PAD_LOAD    = 1;
    localparam int unsigned PAD_START   = 2;
    localparam int unsigned PAD_LOADLEN = 3;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLenHi,
        StLenLo,
        StFill,
        StStart,
        StWait,
        StDone
    } seq_state_e;

    // SHA-384/512 use 1024-bit blocks; every other variant uses 512.
    function automatic int unsigned block_size(input int unsigned mode);
        return (mode == 384 || mode == 512) ? 1024 : 512;
    endfunction

endpackage

// File: rtl/sha2_word_mask.sv
// Tail masking for the final, partially used message word.
// Ports:
//   bits_left : message bits still owed to the block (including this word)
//   data_in   : raw message word, MSB-first
//   data_out  : data_in with every bit past the end of the message cleared;
//               all zero when bits_left is zero
module sha2_word_mask #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] bits_left,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out
);

    localparam logic [WIDTH-1:0]   ALL_ONES = '1;
    localparam logic [2*WIDTH-1:0] WIDTH_L  = (2*WIDTH)'(WIDTH);

    logic [WIDTH-1:0] keep_mask;

    always_comb begin
        keep_mask = ALL_ONES;
        // Keep only the top bits_left bits; a zero count clears the word.
        if (bits_left < WIDTH_L) begin
            keep_mask = ~(ALL_ONES >> bits_left);
        end
    end

    assign data_out = data_in & keep_mask;

endmodule

// File: rtl/sha2_block_sequencer.sv
// Sequences one SHA-2 hash job through the padding unit and compression core.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   job_valid/job_ready     : job request handshake, message length on len_in
//   len_in                  : message length L in bits
//   msg_valid/ready/data    : message word stream, MSB-first
//   blk_we/blk_addr/blk_data: block buffer write port (registered writes)
//   pad_control/pad_ad      : padding-unit control {load_length,start,load,clear}
//                             and address (length half or word index)
//   core_start/core_done    : per-block start pulse and completion from the core
//   busy/hash_done          : job in progress, last block finished pulse
module sha2_block_sequencer
    import sha2_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned MODE  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [2*WIDTH-1:0] len_in,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [WIDTH-1:0]   msg_data,
    output logic               blk_we,
    output logic [4:0]         blk_addr,
    output logic [WIDTH-1:0]   blk_data,
    output logic [3:0]         pad_control,
    output logic [4:0]         pad_ad,
    output logic               core_start,
    input  logic               core_done,
    output logic               busy,
    output logic               hash_done
);

    localparam int unsigned BS     = block_size(MODE);
    localparam int unsigned BS_LOG = $clog2(BS);
    localparam int unsigned LW     = 2 * WIDTH;

    localparam logic [LW-1:0] WIDTH_L   = LW'(WIDTH);
    localparam logic [LW:0]   LEN_FIELD = (LW+1)'(LW);
    localparam logic [4:0]    IDX_END   = 5'(WPB);

    seq_state_e state_q, state_d;

    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    bits_left_q, bits_left_d;
    logic [LW-1:0]    blocks_left_q, blocks_left_d;
    // Next word index to accept; IDX_END means all words of the block are taken.
    logic [4:0]       idx_q, idx_d;
    logic             wr_q, wr_d;
    logic [3:0]       wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    logic [LW:0]      len_plus;
    logic [LW-1:0]    blocks_init;
    logic [WIDTH-1:0] masked_word;
    logic             fill_open;
    logic             word_take;

    // Blocks = floor((L + length field) / BS) + 1, one wider to avoid overflow.
    assign len_plus    = {1'b0, len_in} + LEN_FIELD;
    assign blocks_init = LW'(len_plus >> BS_LOG) + LW'(1);

    sha2_word_mask #(
        .WIDTH(WIDTH)
    ) u_word_mask (
        .bits_left(bits_left_q),
        .data_in  (msg_data),
        .data_out (masked_word)
    );

    // In FILL a slot is open until the last word of the block has been taken.
    assign fill_open = (state_q == StFill) && (idx_q != IDX_END);
    // Once the message is exhausted, zero words are taken without a handshake.
    assign word_take = fill_open && ((bits_left_q == '0) || msg_valid);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        bits_left_d   = bits_left_q;
        blocks_left_d = blocks_left_q;
        idx_d         = idx_q;
        wr_d          = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (job_valid) begin
                    len_d         = len_in;
                    bits_left_d   = len_in;
                    blocks_left_d = blocks_init;
                    idx_d         = '0;
                    state_d       = StClr;
                end
            end
            StClr:   state_d = StLenHi;
            StLenHi: state_d = StLenLo;
            StLenLo: begin
                idx_d   = '0;
                state_d = StFill;
            end
            StFill: begin
                if (idx_q == IDX_END) begin
                    // Word 15's write is on the port this cycle.
                    state_d = StStart;
                end else if (word_take) begin
                    wr_d        = 1'b1;
                    wr_addr_d   = idx_q[3:0];
                    wr_data_d   = masked_word;
                    idx_d       = idx_q + 5'd1;
                    bits_left_d = (bits_left_q > WIDTH_L) ? bits_left_q - WIDTH_L : '0;
                end
            end
            StStart: begin
                blocks_left_d = blocks_left_q - LW'(1);
                state_d       = StWait;
            end
            StWait: begin
                if (core_done) begin
                    if (blocks_left_q != '0) begin
                        idx_d   = '0;
                        state_d = StFill;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            len_q         <= '0;
            bits_left_q   <= '0;
            blocks_left_q <= '0;
            idx_q         <= '0;
            wr_q          <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            bits_left_q   <= bits_left_d;
            blocks_left_q <= blocks_left_d;
            idx_q         <= idx_d;
            wr_q          <= wr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    always_comb begin
        job_ready   = (state_q == StIdle);
        busy        = (state_q != StIdle);
        msg_ready   = fill_open && (bits_left_q != '0);
        core_start  = (state_q == StStart);
        hash_done   = (state_q == StDone);
        blk_we      = wr_q;
        blk_addr    = '0;
        blk_data    = '0;
        pad_control = '0;
        pad_ad      = '0;

        unique case (state_q)
            StClr: pad_control[PAD_CLR] = 1'b1;
            StLenHi: begin
                pad_control[PAD_LOADLEN] = 1'b1;
                pad_ad                   = 5'd0;
                blk_data                 = len_q[LW-1:WIDTH];
            end
            StLenLo: begin
                pad_control[PAD_LOADLEN] = 1'b1;
                pad_ad                   = 5'd1;
                blk_data                 = len_q[WIDTH-1:0];
            end
            StStart: pad_control[PAD_START] = 1'b1;
            default: ;
        endcase

        // Registered write of the word taken in the previous cycle.
        if (wr_q) begin
            pad_control[PAD_LOAD] = 1'b1;
            blk_addr              = {1'b0, wr_addr_q};
            pad_ad                = {1'b0, wr_addr_q};
            blk_data              = wr_data_q;
        end
    end

endmodule

// File: tb/tb_sha2_block_sequencer.sv
module tb_sha2_block_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic         sel;  // 0: 32-bit/SHA-256 instance, 1: 64-bit/SHA-512 instance
    logic         job_valid_t, msg_valid_t, core_done_t;
    logic [127:0] len_t;
    logic [63:0]  msg_data_t;

    logic        a_job_ready, a_msg_ready, a_blk_we, a_core_start, a_busy, a_hash_done;
    logic [4:0]  a_blk_addr, a_pad_ad;
    logic [31:0] a_blk_data;
    logic [3:0]  a_pad_control;
    logic        b_job_ready, b_msg_ready, b_blk_we, b_core_start, b_busy, b_hash_done;
    logic [4:0]  b_blk_addr, b_pad_ad;
    logic [63:0] b_blk_data;
    logic [3:0]  b_pad_control;

    sha2_block_sequencer #(.WIDTH(32), .MODE(256)) u_dut_a (
        .clk(clk), .rst(rst),
        .job_valid(job_valid_t & ~sel), .job_ready(a_job_ready), .len_in(len_t[63:0]),
        .msg_valid(msg_valid_t & ~sel), .msg_ready(a_msg_ready), .msg_data(msg_data_t[31:0]),
        .blk_we(a_blk_we), .blk_addr(a_blk_addr), .blk_data(a_blk_data),
        .pad_control(a_pad_control), .pad_ad(a_pad_ad),
        .core_start(a_core_start), .core_done(core_done_t & ~sel),
        .busy(a_busy), .hash_done(a_hash_done)
    );

    sha2_block_sequencer #(.WIDTH(64), .MODE(512)) u_dut_b (
        .clk(clk), .rst(rst),
        .job_valid(job_valid_t & sel), .job_ready(b_job_ready), .len_in(len_t),
        .msg_valid(msg_valid_t & sel), .msg_ready(b_msg_ready), .msg_data(msg_data_t),
        .blk_we(b_blk_we), .blk_addr(b_blk_addr), .blk_data(b_blk_data),
        .pad_control(b_pad_control), .pad_ad(b_pad_ad),
        .core_start(b_core_start), .core_done(core_done_t & sel),
        .busy(b_busy), .hash_done(b_hash_done)
    );

    logic        m_job_ready, m_msg_ready, m_blk_we, m_core_start, m_busy, m_hash_done;
    logic [4:0]  m_blk_addr, m_pad_ad;
    logic [63:0] m_blk_data;
    logic [3:0]  m_pad_control;
    assign m_job_ready   = sel ? b_job_ready   : a_job_ready;
    assign m_msg_ready   = sel ? b_msg_ready   : a_msg_ready;
    assign m_blk_we      = sel ? b_blk_we      : a_blk_we;
    assign m_core_start  = sel ? b_core_start  : a_core_start;
    assign m_busy        = sel ? b_busy        : a_busy;
    assign m_hash_done   = sel ? b_hash_done   : a_hash_done;
    assign m_blk_addr    = sel ? b_blk_addr    : a_blk_addr;
    assign m_pad_ad      = sel ? b_pad_ad      : a_pad_ad;
    assign m_blk_data    = sel ? b_blk_data    : {32'h0, a_blk_data};
    assign m_pad_control = sel ? b_pad_control : a_pad_control;

    int checks = 0;
    int errors = 0;

    // Job stimulus and observations.
    logic [63:0] words[$];
    logic [4:0]  wr_addr[$];
    logic [63:0] wr_data[$];
    logic [4:0]  len_ad[$];
    logic [63:0] len_dat[$];
    int start_cnt, hash_cnt, hash_cyc, done_cyc, accepted, side_bad, gap_we_bad;
    bit timed_out;

    function automatic int wbits();
        return sel ? 64 : 32;
    endfunction

    function automatic longint unsigned exp_blocks(input longint unsigned l, input int w);
        longint unsigned bs;
        bs = (w == 64) ? 1024 : 512;
        return (l + 2 * w) / bs + 1;
    endfunction

    function automatic int exp_words(input longint unsigned l, input int w);
        return int'((l + w - 1) / w);
    endfunction

    // Global word k of the job: message word truncated at bit L, then zeros.
    function automatic logic [63:0] exp_word(input int k, input longint unsigned l, input int w);
        longint unsigned consumed, rem;
        logic [63:0] v;
        consumed = longint'(k) * w;
        if (l <= consumed || k >= words.size()) return 64'h0;
        rem = l - consumed;
        v = words[k];
        if (rem < w) v = (v >> (w - rem)) << (w - rem);
        return v;
    endfunction

    function automatic int count_bad_writes(input longint unsigned l, input int w);
        int bad, n;
        bad = 0;
        n = int'(exp_blocks(l, w)) * 16;
        if (wr_data.size() != n) bad++;
        for (int k = 0; k < wr_data.size() && k < n; k++) begin
            if (wr_data[k] !== exp_word(k, l, w) || wr_addr[k] !== 5'(k % 16)) bad++;
        end
        return bad;
    endfunction

    task automatic gen_words(input longint unsigned l);
        int w;
        logic [63:0] v;
        w = wbits();
        words.delete();
        for (int i = 0; longint'(i) * w < l; i++) begin
            v = {$urandom, $urandom};
            if (w == 32) v[63:32] = 32'h0;
            words.push_back(v);
        end
    endtask

    // Runs one job on the selected instance; core answers each start after 1..4 cycles.
    task automatic run_job(input longint unsigned l, input bit gaps, input bit early,
                           input bit abort);
        int idx, resp_wait;
        bit stall_prev, seen_hash;
        idx = 0; resp_wait = 0; stall_prev = 0; seen_hash = 0;
        wr_addr.delete(); wr_data.delete(); len_ad.delete(); len_dat.delete();
        start_cnt = 0; hash_cnt = 0; hash_cyc = -1; done_cyc = -100;
        accepted = 0; side_bad = 0; gap_we_bad = 0;
        @(negedge clk);
        len_t = 128'(l);
        job_valid_t = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            job_valid_t = 1'b0;
            if (m_blk_we) begin
                wr_addr.push_back(m_blk_addr);
                wr_data.push_back(m_blk_data);
                if (m_pad_control !== 4'b0010 || m_pad_ad !== m_blk_addr) side_bad++;
                if (stall_prev) gap_we_bad++;
            end
            if (m_pad_control == 4'b1000) begin
                len_ad.push_back(m_pad_ad);
                len_dat.push_back(m_blk_data);
            end
            if (m_core_start) begin
                start_cnt++;
                resp_wait = $urandom_range(2, 5);
            end
            if (m_hash_done) begin
                hash_cnt++;
                hash_cyc = cyc;
                seen_hash = 1'b1;
            end
            if (seen_hash) break;
            if (abort && start_cnt == 1 && !m_core_start) break;
            core_done_t = 1'b0;
            if (resp_wait > 0) begin
                resp_wait--;
                if (resp_wait == 0) begin
                    core_done_t = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (early && c == 12) core_done_t = 1'b1;
            if (idx >= words.size()) begin
                msg_valid_t = 1'b1;  // surplus words must never be taken
                msg_data_t = {$urandom, $urandom};
            end else if (gaps && (c % 3 == 2)) begin
                msg_valid_t = 1'b0;
            end else begin
                msg_valid_t = 1'b1;
                msg_data_t = words[idx];
            end
            stall_prev = m_msg_ready && !msg_valid_t;
            if (m_msg_ready && msg_valid_t) begin
                idx++;
                accepted++;
            end
        end
        timed_out = abort ? (start_cnt != 1) : !seen_hash;
        msg_valid_t = 1'b0;
        core_done_t = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_job_ready, a_busy, a_msg_ready, a_blk_we, a_core_start, a_hash_done,
             a_pad_control, a_pad_ad, a_blk_addr, a_blk_data} !== {1'b1, 51'h0}) begin
            errors++;
            $display("FAIL reset_a: got rdy=%b busy=%b mrdy=%b we=%b cs=%b hd=%b pc=%h ad=%h data=%h, want rdy=1 rest 0",
                     a_job_ready, a_busy, a_msg_ready, a_blk_we, a_core_start, a_hash_done,
                     a_pad_control, a_pad_ad, a_blk_data);
        end
        checks++;
        if ({b_job_ready, b_busy, b_msg_ready, b_blk_we, b_core_start, b_hash_done,
             b_pad_control, b_pad_ad, b_blk_addr, b_blk_data} !== {1'b1, 83'h0}) begin
            errors++;
            $display("FAIL reset_b: got rdy=%b busy=%b we=%b pc=%h data=%h, want rdy=1 rest 0",
                     b_job_ready, b_busy, b_blk_we, b_pad_control, b_blk_data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero_len();
        int bad;
        sel = 1'b0;
        gen_words(0);
        run_job(0, 0, 0, 0);
        bad = count_bad_writes(0, 32);
        checks++;
        if (timed_out) begin errors++; $display("FAIL zero_len timeout: got no hash_done, want one"); end
        checks++;
        if (bad !== 0 || wr_data.size() !== 16) begin
            errors++; $display("FAIL zero_len writes: got %0d bad of %0d, want 0 of 16", bad, wr_data.size());
        end
        checks++;
        if (accepted !== 0) begin errors++; $display("FAIL zero_len handshakes: got %0d, want 0", accepted); end
        checks++;
        if (start_cnt !== 1) begin errors++; $display("FAIL zero_len starts: got %0d, want 1", start_cnt); end
        checks++;
        if (hash_cyc !== done_cyc + 1) begin
            errors++; $display("FAIL zero_len hash_timing: got cycle %0d, want %0d", hash_cyc, done_cyc + 1);
        end
    endtask

    task automatic test_tail_mask();
        sel = 1'b0;
        gen_words(24);
        words[0] = 64'h6162_63FF;
        run_job(24, 0, 0, 0);
        checks++;
        if (wr_data.size() < 1 || wr_data[0] !== 64'h6162_6300) begin
            errors++; $display("FAIL tail_mask word0: got %h, want 61626300", wr_data.size() ? wr_data[0] : 64'hx);
        end
        checks++;
        if (count_bad_writes(24, 32) !== 0 || side_bad !== 0) begin
            errors++; $display("FAIL tail_mask writes: got %0d bad, %0d side, want 0", count_bad_writes(24, 32), side_bad);
        end
        checks++;
        if (len_dat.size() !== 2 || len_ad[0] !== 5'd0 || len_dat[0] !== 64'h0 ||
            len_ad[1] !== 5'd1 || len_dat[1] !== 64'h18) begin
            errors++; $display("FAIL tail_mask length: got %0d entries last ad=%0d data=%h, want 2 ad=1 data=18",
                               len_dat.size(), len_ad.size() ? len_ad[len_ad.size()-1] : 5'h1f,
                               len_dat.size() ? len_dat[len_dat.size()-1] : 64'hx);
        end
        checks++;
        if (start_cnt !== 1 || hash_cnt !== 1) begin
            errors++; $display("FAIL tail_mask starts: got %0d/%0d, want 1/1", start_cnt, hash_cnt);
        end
    endtask

    task automatic test_two_blocks();
        sel = 1'b0;
        gen_words(448);
        run_job(448, 0, 0, 0);
        checks++;
        if (count_bad_writes(448, 32) !== 0) begin
            errors++; $display("FAIL two_blocks writes: got %0d bad of %0d, want 0 of 32",
                               count_bad_writes(448, 32), wr_data.size());
        end
        checks++;
        if (start_cnt !== 2 || accepted !== 14) begin
            errors++; $display("FAIL two_blocks counts: got starts=%0d words=%0d, want 2/14", start_cnt, accepted);
        end
        checks++;
        if (hash_cyc !== done_cyc + 1 || hash_cnt !== 1) begin
            errors++; $display("FAIL two_blocks hash_timing: got %0d, want %0d", hash_cyc, done_cyc + 1);
        end
    endtask

    task automatic test_gaps();
        sel = 1'b0;
        gen_words(1024);
        run_job(1024, 1, 1, 0);
        checks++;
        if (gap_we_bad !== 0) begin errors++; $display("FAIL gaps stall_write: got %0d, want 0", gap_we_bad); end
        checks++;
        if (count_bad_writes(1024, 32) !== 0 || side_bad !== 0) begin
            errors++; $display("FAIL gaps writes: got %0d bad of %0d, want 0 of 48",
                               count_bad_writes(1024, 32), wr_data.size());
        end
        checks++;
        if (start_cnt !== 3 || accepted !== 32 || timed_out) begin
            errors++; $display("FAIL gaps counts: got starts=%0d words=%0d, want 3/32", start_cnt, accepted);
        end
    endtask

    task automatic test_abort();
        int hd;
        sel = 1'b0;
        gen_words(448);
        run_job(448, 0, 0, 1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL abort reach_wait: got starts=%0d, want 1", start_cnt); end
        rst = 1'b0;
        #1;
        checks++;
        if ({m_job_ready, m_busy, m_hash_done, m_core_start, m_blk_we} !== 5'b10000) begin
            errors++; $display("FAIL abort reset_now: got rdy/busy/hd/cs/we=%b, want 10000",
                               {m_job_ready, m_busy, m_hash_done, m_core_start, m_blk_we});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            core_done_t = (c == 1);
            if (m_hash_done || m_busy) hd++;
        end
        core_done_t = 1'b0;
        checks++;
        if (hd !== 0) begin errors++; $display("FAIL abort after_reset: got %0d busy/done cycles, want 0", hd); end
        gen_words(24);
        run_job(24, 0, 0, 0);
        checks++;
        if (timed_out || start_cnt !== 1 || count_bad_writes(24, 32) !== 0) begin
            errors++; $display("FAIL abort next_job: got starts=%0d bad=%0d, want 1/0",
                               start_cnt, count_bad_writes(24, 32));
        end
    endtask

    task automatic test_wide();
        sel = 1'b1;
        gen_words(895);
        run_job(895, 0, 0, 0);
        checks++;
        if (start_cnt !== 1 || accepted !== 14 || count_bad_writes(895, 64) !== 0) begin
            errors++; $display("FAIL wide_895: got starts=%0d words=%0d bad=%0d, want 1/14/0",
                               start_cnt, accepted, count_bad_writes(895, 64));
        end
        gen_words(896);
        run_job(896, 1, 0, 0);
        checks++;
        if (start_cnt !== 2 || accepted !== 14 || count_bad_writes(896, 64) !== 0) begin
            errors++; $display("FAIL wide_896: got starts=%0d words=%0d bad=%0d, want 2/14/0",
                               start_cnt, accepted, count_bad_writes(896, 64));
        end
        checks++;
        if (len_dat.size() !== 2 || len_dat[1] !== 64'd896 || len_dat[0] !== 64'd0) begin
            errors++; $display("FAIL wide_len: got %0d entries, want hi=0 lo=896", len_dat.size());
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        longint unsigned l;
        int w;
        bit g;
        for (int t = 0; t < 8; t++) begin
            sel = 1'($urandom_range(0, 1));
            w = wbits();
            l = $urandom_range(0, sel ? 2200 : 1100);
            g = 1'($urandom_range(0, 1));
            gen_words(l);
            run_job(l, g, 0, 0);
            checks++;
            if (timed_out || longint'(start_cnt) != exp_blocks(l, w) || accepted != exp_words(l, w) ||
                hash_cyc != done_cyc + 1) begin
                errors++; $display("FAIL random_%0d counts: L=%0d w=%0d got starts=%0d words=%0d, want %0d/%0d",
                                   t, l, w, start_cnt, accepted, exp_blocks(l, w), exp_words(l, w));
            end
            checks++;
            if (count_bad_writes(l, w) !== 0 || side_bad !== 0 || gap_we_bad !== 0) begin
                errors++; $display("FAIL random_%0d writes: L=%0d got %0d bad %0d side %0d gap, want 0",
                                   t, l, count_bad_writes(l, w), side_bad, gap_we_bad);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        job_valid_t = 1'b0;
        msg_valid_t = 1'b0;
        core_done_t = 1'b0;
        len_t = '0;
        msg_data_t = '0;
        test_reset();
        test_zero_len();
        test_tail_mask();
        test_two_blocks();
        test_gaps();
        test_abort();
        test_wide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
